multicycle_ctrl: RTL and testbench

- Moore-style sequencer for a multicycle version of the MIPS-subset datapath (pc, ins_mem/mem, reg_bank, alu, alu_control).
- Replaces the single-cycle `control` decoder: walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB steps and drives every datapath enable and mux select.
- Handles a ready handshake from the shared instruction/data memory.
- Traps on illegal opcodes and memory timeouts.

---
 rtl/multicycle_ctrl.sv | 156 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer for the multicycle MIPS-subset datapath.
// Define MULTICYCLE_CTRL_PERF_EN to enable the retired-instruction counter on instr_cnt.
module multicycle_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemToReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] instr_cnt
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I,
        MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, TRAP
    } state_t;
    state_t state, next;
    logic [CNT_W-1:0] cnt;
    logic mem_st, timeout;
    assign mem_st  = state inside {FETCH, MEM_RD, MEM_WR};
    assign timeout = mem_st && !mem_ready && cnt == CNT_W'(TIMEOUT);
    // State, memory wait counter and sticky trap cause
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            state <= next;
            cnt   <= (mem_st && next == state) ? cnt + 1'b1 : '0;
            err   <= err | (next == TRAP);
            if (next == TRAP && !err)
                err_code <= timeout ? 2'b10 : 2'b01;
        end
    end
    // Next state and datapath controls; only FETCH gates its enables on mem_ready
    always_comb begin
        next        = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        PCSource    = 2'b00;
        case (state)
            IDLE: next = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                next    = mem_ready ? DECODE : timeout ? TRAP : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    6'b000000:            next = EXEC_R;
                    6'b100011, 6'b101011: next = MEM_ADDR;
                    6'b000100:            next = BRANCH;
                    6'b000010:            next = JUMP;
                    6'b001000:            next = EXEC_I;
                    default:              next = TRAP;
                endcase
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
                next    = WB_R;
            end
            WB_R: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                next     = FETCH;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next    = WB_I;
            end
            WB_I: begin
                RegWrite = 1'b1;
                next     = FETCH;
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next    = (opcode == 6'b100011) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                next    = mem_ready ? WB_MEM : timeout ? TRAP : MEM_RD;
            end
            WB_MEM: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
                next     = FETCH;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                next     = mem_ready ? FETCH : timeout ? TRAP : MEM_WR;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                next        = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                next     = FETCH;
            end
            TRAP: next = TRAP;
            default: next = IDLE;
        endcase
    end
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic retire;
    assign retire = next == FETCH && state inside {WB_R, WB_I, WB_MEM, MEM_WR, BRANCH, JUMP};
    // Count instructions as they complete and hand control back to FETCH
    always_ff @(posedge clk) begin
        if (rst)
            instr_cnt <= '0;
        else if (retire)
            instr_cnt <= instr_cnt + 32'd1;
    end
`else
    assign instr_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction streams checked cycle by cycle against per-instruction control scripts.
module tb_multicycle_ctrl;
    logic        clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemToReg, RegDst, RegWrite, ALUSrcA, err;
    logic [1:0]  ALUSrcB, PCSource, err_code;
    logic [2:0]  ALUOp;
    logic [31:0] instr_cnt;
    int total = 0, bad = 0, exp_cnt = 0;

    typedef struct packed {
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] pcs;
    } ctl_t;
    ctl_t obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .err(err), .err_code(err_code), .instr_cnt(instr_cnt)
    );

    function automatic ctl_t c(logic pcw, logic pcwc, logic iord, logic mr, logic mw, logic irw,
                               logic m2r, logic rd, logic rw, logic asa,
                               logic [1:0] asb, logic [2:0] aop, logic [1:0] pcs);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
    endfunction

    //                 pcw pcwc iord mr mw irw m2r rd rw asa  asb    aop     pcs
    ctl_t ZERO = c(0,  0,   0,   0, 0, 0,  0,  0, 0, 0, 2'b00, 3'b000, 2'b00);
    ctl_t F_W  = c(0,  0,   0,   1, 0, 0,  0,  0, 0, 0, 2'b01, 3'b000, 2'b00);
    ctl_t F_R  = c(1,  0,   0,   1, 0, 1,  0,  0, 0, 0, 2'b01, 3'b000, 2'b00);
    ctl_t DEC  = c(0,  0,   0,   0, 0, 0,  0,  0, 0, 0, 2'b11, 3'b000, 2'b00);
    ctl_t EXR  = c(0,  0,   0,   0, 0, 0,  0,  0, 0, 1, 2'b00, 3'b010, 2'b00);
    ctl_t WBR  = c(0,  0,   0,   0, 0, 0,  0,  1, 1, 0, 2'b00, 3'b000, 2'b00);
    ctl_t EXI  = c(0,  0,   0,   0, 0, 0,  0,  0, 0, 1, 2'b10, 3'b000, 2'b00);
    ctl_t WBI  = c(0,  0,   0,   0, 0, 0,  0,  0, 1, 0, 2'b00, 3'b000, 2'b00);
    ctl_t MAD  = c(0,  0,   0,   0, 0, 0,  0,  0, 0, 1, 2'b10, 3'b000, 2'b00);
    ctl_t MRD  = c(0,  0,   1,   1, 0, 0,  0,  0, 0, 0, 2'b00, 3'b000, 2'b00);
    ctl_t WBM  = c(0,  0,   0,   0, 0, 0,  1,  0, 1, 0, 2'b00, 3'b000, 2'b00);
    ctl_t MWR  = c(0,  0,   1,   0, 1, 0,  0,  0, 0, 0, 2'b00, 3'b000, 2'b00);
    ctl_t BRN  = c(0,  1,   0,   0, 0, 0,  0,  0, 0, 1, 2'b00, 3'b001, 2'b01);
    ctl_t JMP  = c(1,  0,   0,   0, 0, 0,  0,  0, 0, 0, 2'b00, 3'b000, 2'b10);

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] cnt_exp();
`ifdef MULTICYCLE_CTRL_PERF_EN
        return exp_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic step(string tag, logic rdy, ctl_t want);
        mem_ready = rdy;
        @(negedge clk);
        check(tag, 32'(obs), 32'(want));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", 32'(obs), 32'(ZERO));
        check("rst_err", {30'd0, err_code}, 32'd0);
        check("rst_errflag", 32'(err), 32'd0);
        check("rst_cnt", instr_cnt, 32'd0);
        rst = 1'b0;
        exp_cnt = 0;
        step("idle", 1'($urandom), ZERO);
    endtask

    // kind: 0 R-type, 1 lw, 2 sw, 3 beq, 4 j, 5 addi; fw/mw are memory wait cycles
    task automatic run_instr(int kind, int fw, int mw);
        logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        opcode = ops[kind];
        for (int i = 0; i < fw; i++) step("fetch_wait", 1'b0, F_W);
        step("fetch", 1'b1, F_R);
        step("decode", 1'($urandom), DEC);
        case (kind)
            0: begin step("exec_r", 1'($urandom), EXR); step("wb_r", 1'($urandom), WBR); end
            1: begin
                step("mem_addr", 1'($urandom), MAD);
                for (int i = 0; i < mw; i++) step("mem_rd_wait", 1'b0, MRD);
                step("mem_rd", 1'b1, MRD);
                step("wb_mem", 1'($urandom), WBM);
            end
            2: begin
                step("mem_addr", 1'($urandom), MAD);
                for (int i = 0; i < mw; i++) step("mem_wr_wait", 1'b0, MWR);
                step("mem_wr", 1'b1, MWR);
            end
            3: step("branch", 1'($urandom), BRN);
            4: step("jump", 1'($urandom), JMP);
            default: begin step("exec_i", 1'($urandom), EXI); step("wb_i", 1'($urandom), WBI); end
        endcase
        exp_cnt++;
        check("instr_cnt", instr_cnt, cnt_exp());
        check("no_err", 32'(err), 32'd0);
    endtask

    task automatic expect_trap(logic [1:0] code, int cycles);
        for (int i = 0; i < cycles; i++) begin
            step("trap_ctl", 1'($urandom), ZERO);
            check("trap_err", 32'(err), 32'd1);
            check("trap_code", {30'd0, err_code}, {30'd0, code});
            check("trap_cnt", instr_cnt, cnt_exp());
        end
    endtask

    initial begin
        logic [5:0] bad_op;
        do_reset();
        run_instr(0, 0, 0);
        run_instr(2, 0, 0);
        run_instr(3, 0, 0);
        run_instr(4, 0, 0);
        run_instr(5, 0, 0);
        check("cnt_five", instr_cnt, cnt_exp());
        run_instr(1, 0, 3);
        run_instr(0, 4, 0);
        run_instr(2, 2, 4);
        for (int n = 0; n < 40; n++)
            run_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
        // illegal opcode
        do bad_op = 6'($urandom);
        while (bad_op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
        opcode = bad_op;
        step("fetch", 1'b1, F_R);
        step("decode", 1'($urandom), DEC);
        expect_trap(2'b01, 20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_clears_err", 32'(err), 32'd0);
        check("rst_clears_ctl", 32'(obs), 32'(ZERO));
        do_reset();
        // fetch timeout
        opcode = 6'b000000;
        for (int i = 0; i < 5; i++) step("fetch_to", 1'b0, F_W);
        expect_trap(2'b10, 3);
        do_reset();
        // lw read timeout
        run_instr(3, 1, 0);
        opcode = 6'b100011;
        step("fetch", 1'b1, F_R);
        step("decode", 1'b0, DEC);
        step("mem_addr", 1'b0, MAD);
        for (int i = 0; i < 5; i++) step("mem_rd_to", 1'b0, MRD);
        expect_trap(2'b10, 3);
        do_reset();
        // sw write timeout
        opcode = 6'b101011;
        step("fetch", 1'b1, F_R);
        step("decode", 1'b0, DEC);
        step("mem_addr", 1'b0, MAD);
        for (int i = 0; i < 5; i++) step("mem_wr_to", 1'b0, MWR);
        expect_trap(2'b10, 2);
        do_reset();
        // reset during WB_MEM aborts the write-back
        run_instr(0, 0, 0);
        run_instr(5, 1, 0);
        opcode = 6'b100011;
        step("fetch", 1'b1, F_R);
        step("decode", 1'b0, DEC);
        step("mem_addr", 1'b0, MAD);
        step("mem_rd", 1'b1, MRD);
        mem_ready = 1'b0;
        @(negedge clk);
        check("wb_mem_pre_rst", 32'(obs), 32'(WBM));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ctl", 32'(obs), 32'(ZERO));
        check("abort_cnt", instr_cnt, 32'd0);
        rst = 1'b0;
        exp_cnt = 0;
        step("idle_after_abort", 1'b1, ZERO);
        run_instr(1, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
